// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned INST_W = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_SKID = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ifu_if_id_reg.sv
// IF/ID pipeline register: load a new instruction, hold under stall, bubble on flush.
module if_id_reg
    import ifu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [INST_W-1:0] inst_i,
    output logic              valid_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [INST_W-1:0] inst_o
);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            inst_d  = inst_i;
        end else if (!valid_q || !stall_i) begin
            // downstream consumed the entry and nothing replaces it
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding imem request, skid for stalled responses, redirect handling.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_b_j,
    input  logic [XLEN-1:0]   dnpc,
    input  logic              if_id_stall,
    output logic              imem_req_valid,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              if_id_valid,
    output logic [XLEN-1:0]   if_id_pc,
    output logic [INST_W-1:0] if_id_inst
);

    ifu_state_e        state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] skid_q, skid_d;

    logic              load_ok;
    logic              handshake;
    logic              ifid_load;
    logic [INST_W-1:0] ifid_inst;

    assign imem_req_valid = (state_q == S_REQ) && !rst;
    assign imem_req_addr  = pc_q;
    assign handshake      = imem_req_valid && imem_req_ready;
    assign load_ok        = !if_id_valid || !if_id_stall;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        skid_d    = skid_q;
        ifid_load = 1'b0;
        ifid_inst = imem_resp_data;
        unique case (state_q)
            S_REQ: begin
                if (pc_b_j) begin
                    pc_d = dnpc;
                    if (handshake) state_d = S_DROP;
                end else if (handshake) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pc_b_j) begin
                    pc_d    = dnpc;
                    state_d = imem_resp_valid ? S_REQ : S_DROP;
                end else if (imem_resp_valid) begin
                    if (load_ok) begin
                        ifid_load = 1'b1;
                        pc_d      = pc_q + 64'd4;
                        state_d   = S_REQ;
                    end else begin
                        skid_d  = imem_resp_data;
                        state_d = S_SKID;
                    end
                end
            end
            S_DROP: begin
                if (pc_b_j) pc_d = dnpc;
                if (imem_resp_valid) state_d = S_REQ;
            end
            S_SKID: begin
                if (pc_b_j) begin
                    pc_d    = dnpc;
                    state_d = S_REQ;
                end else if (load_ok) begin
                    ifid_load = 1'b1;
                    ifid_inst = skid_q;
                    pc_d      = pc_q + 64'd4;
                    state_d   = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ifid_load),
        .flush_i (pc_b_j),
        .stall_i (if_id_stall),
        .pc_i    (pc_q),
        .inst_i  (ifid_inst),
        .valid_o (if_id_valid),
        .pc_o    (if_id_pc),
        .inst_o  (if_id_inst)
    );

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the RV64 five-stage core. Holds the fetch PC, issues one outstanding request at a time to instruction memory over a valid/ready request channel, and captures the returned 32-bit instruction into the IF/ID pipeline register. It consumes `pc_b_j`/`dnpc` from the ID-stage branch/jump unit to redirect fetch, discarding wrong-path instructions.

## Interface
Parameters:
- `RESET_PC`, 64'h8000_0000, first fetch address after reset.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pc_b_j`  in  1  redirect request from ID (already gated by `~if_id_stall` upstream).
- `dnpc`  in  64  redirect target, valid when `pc_b_j`=1.
- `if_id_stall`  in  1  ID cannot accept a new instruction this cycle.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  64  fetch address.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_resp_valid`  in  1  response valid (≥1 cycle after accepted request).
- `imem_resp_data`  in  32  fetched instruction.
- `if_id_valid`  out  1  IF/ID holds a valid instruction.
- `if_id_pc`  out  64  PC of that instruction.
- `if_id_inst`  out  32  the instruction.

## Operation
- `pc` register = address of the instruction currently requested, in flight, or held in skid; increments by 4 only when that instruction enters IF/ID.
- `load_ok` = `~if_id_valid | ~if_id_stall`.
- Priority each cycle: `rst` > `pc_b_j` > normal flow.
- States:
  - S_REQ: `imem_req_valid`=1, `imem_req_addr`=`pc`. Handshake (valid&ready) → S_WAIT. Redirect without handshake: `pc`←`dnpc`, stay. Redirect with handshake same cycle: `pc`←`dnpc`, → S_DROP.
  - S_WAIT: on `imem_resp_valid`: if `load_ok`, load IF/ID (`if_id_pc`←`pc`, `if_id_inst`←data, valid←1), `pc`←`pc`+4, → S_REQ; else store data in skid, → S_SKID. Redirect (with or without response): response discarded, `pc`←`dnpc`, → S_REQ if response arrived this cycle else S_DROP.
  - S_DROP: wait for response, discard it, → S_REQ. Redirect here: `pc`←`dnpc`, stay until response.
  - S_SKID: no request. When `load_ok`: skid → IF/ID, `pc`←`pc`+4, → S_REQ. Redirect: skid invalidated, `pc`←`dnpc`, → S_REQ.
- IF/ID on redirect: `if_id_valid`←0 next cycle (bubble), regardless of state.
- IF/ID when `if_id_stall` and valid: holds all fields.
- IF/ID when `load_ok` and nothing new to load: `if_id_valid`←0, pc/inst unchanged.
- `imem_resp_valid` outside S_WAIT/S_DROP: ignored (protocol violation, assertion in bench).
- `dnpc` used verbatim; no alignment check. `pc`+4 wraps modulo 2^64.

## Timing
- Reset (any state, mid-fetch included): next cycle `pc`=`RESET_PC`, state S_REQ, `if_id_valid`=0, `if_id_pc`=0, `if_id_inst`=0, skid empty. While `rst`=1, `imem_req_valid`=0. An in-flight response arriving after reset is not tracked (memory must be reset alongside).
- `imem_req_valid`/`imem_req_addr` are functions of registered state only; no combinational path from `pc_b_j` or `imem_*` inputs to request outputs.
- Zero-wait memory (ready=1, response 1 cycle later): one instruction per 2 cycles; first IF/ID valid 2 cycles after reset release.
- Redirect in cycle N: request to `dnpc` issued in N+1 (from S_REQ/S_WAIT-with-response/S_SKID) or cycle after stale response (S_DROP).

## Structure
- Package `ifu_pkg`: state enum {S_REQ, S_WAIT, S_DROP, S_SKID}, `RESET_PC` default, `INST_W`=32, `XLEN`=64.
- One sub-module natural: `if_id_reg` (valid/pc/inst with load, hold, flush inputs). Skid buffer stays inline (32-bit data + state).

## Test plan
- Reset release, memory ready=1, 1-cycle response, data 0x00000013 → IF/ID valid with pc 0x8000_0000 then 0x8000_0004 on alternate cycles.
- `pc_b_j`=1, `dnpc`=0x8000_0100 while in S_WAIT, response arrives 2 cycles later → response dropped, `if_id_valid` 0, next request addr 0x8000_0100.
- `if_id_stall`=1 with IF/ID valid, response 0xDEADBEEF arrives → S_SKID, no request; stall drops → IF/ID inst 0xDEADBEEF, next request at pc+4.
- Redirect coincident with request handshake in S_REQ → S_DROP, stale response discarded, next request at `dnpc`.
- Redirect in S_SKID → skid discarded, request at `dnpc` next cycle, IF/ID bubble.
- `rst` pulsed while in S_WAIT → all outputs at reset values, next request at 0x8000_0000.
